// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and architectural constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_WAIT = 2'd2,
      FS_HOLD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus: single-outstanding request channel plus a response channel without backpressure.
interface if_fetch_unit_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one read at a time and fills the IF/ID register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   FS_IDLE | one cycle after reset; latches pc into req_addr
//   FS_REQ  | request presented on the bus until accepted
//   FS_WAIT | request accepted, waiting for the single response beat
//   FS_HOLD | response captured in the hold buffer while downstream stalls
module if_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             new_pc,
   input  logic                    redirect,
   input  logic                    stall,
   output logic [31:0]             pc,
   output logic                    im_busy,
   output logic                    ifid_valid,
   output logic [31:0]             ifid_pc,
   output logic [31:0]             ifid_inst,
   if_fetch_unit_if.master         im
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic         squash_q, squash_d;
   logic [31:0]  hold_q, hold_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [31:0]  ifid_pc_q, ifid_pc_d;
   logic [31:0]  ifid_inst_q, ifid_inst_d;

   logic         deliver;
   logic [31:0]  dlv_inst;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      squash_d   = squash_q;
      hold_d     = hold_q;
      deliver    = 1'b0;
      dlv_inst   = im.rsp_data;

      case (state_q)
         FS_IDLE: begin
            if (redirect) pc_d = new_pc;
            req_addr_d = pc_d;
            state_d    = FS_REQ;
         end
         FS_REQ: begin
            // The presented request cannot be withdrawn, so a redirect only marks it for discard.
            if (redirect) begin
               pc_d     = new_pc;
               squash_d = 1'b1;
            end
            if (im.req_ready) state_d = FS_WAIT;
         end
         FS_WAIT: begin
            if (im.rsp_valid) begin
               if (squash_q || redirect) begin
                  squash_d = 1'b0;
                  if (redirect) pc_d = new_pc;
                  req_addr_d = pc_d;
                  state_d    = FS_REQ;
               end else if (stall) begin
                  hold_d  = im.rsp_data;
                  state_d = FS_HOLD;
               end else begin
                  deliver    = 1'b1;
                  pc_d       = new_pc;
                  req_addr_d = new_pc;
                  state_d    = FS_REQ;
               end
            end else if (redirect) begin
               pc_d     = new_pc;
               squash_d = 1'b1;
            end
         end
         FS_HOLD: begin
            if (redirect) begin
               pc_d       = new_pc;
               req_addr_d = new_pc;
               state_d    = FS_REQ;
            end else if (!stall) begin
               deliver    = 1'b1;
               dlv_inst   = hold_q;
               pc_d       = new_pc;
               req_addr_d = new_pc;
               state_d    = FS_REQ;
            end
         end
         default: state_d = FS_IDLE;
      endcase

      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_inst_d  = ifid_inst_q;
      if (redirect) begin
         ifid_valid_d = 1'b0;
      end else if (stall) begin
         ifid_valid_d = ifid_valid_q;
      end else if (deliver) begin
         ifid_valid_d = 1'b1;
         ifid_pc_d    = req_addr_q;
         ifid_inst_d  = dlv_inst;
      end else begin
         ifid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FS_IDLE;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         squash_q     <= 1'b0;
         hold_q       <= NOP_INST;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= 32'h0000_0000;
         ifid_inst_q  <= NOP_INST;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         squash_q     <= squash_d;
         hold_q       <= hold_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_inst_q  <= ifid_inst_d;
      end
   end

   assign pc           = pc_q;
   assign im_busy      = ~deliver;
   assign ifid_valid   = ifid_valid_q;
   assign ifid_pc      = ifid_pc_q;
   assign ifid_inst    = ifid_inst_q;
   assign im.req_valid = (state_q == FS_REQ);
   assign im.req_addr  = req_addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic against a transaction-level fetch model.
module tb_if_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] new_pc;
   logic        redirect;
   logic        stall;
   logic [31:0] pc;
   logic        im_busy;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_inst;

   if_fetch_unit_if im_bus ();

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .new_pc     (new_pc),
      .redirect   (redirect),
      .stall      (stall),
      .pc         (pc),
      .im_busy    (im_busy),
      .ifid_valid (ifid_valid),
      .ifid_pc    (ifid_pc),
      .ifid_inst  (ifid_inst),
      .im         (im_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: where the one fetch transaction is in its life, plus architectural state.
   bit          m_fresh;     // first cycle after reset, nothing presented yet
   bit          m_present;   // request on the bus, not yet accepted
   bit          m_flight;    // accepted, response not yet returned
   bit          m_killed;    // in-flight/presented fetch belongs to an old path
   bit          m_buf;       // response parked while downstream is stalled
   logic [31:0] m_pc, m_addr, m_buf_data, out_addr;
   bit          m_ifid_v;
   logic [31:0] m_ifid_pc, m_ifid_inst;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0; stall = 1'b0; new_pc = 32'h0;
      im_bus.req_ready = 1'b0; im_bus.rsp_valid = 1'b0; im_bus.rsp_data = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      m_fresh = 1; m_present = 0; m_flight = 0; m_killed = 0; m_buf = 0;
      m_pc = 32'h0; m_addr = 32'h0; m_buf_data = 32'h0; out_addr = 32'h0;
      m_ifid_v = 0; m_ifid_pc = 32'h0; m_ifid_inst = NOP_INST;
      #2;
      chk("rst_pc",        pc,               32'h0);
      chk("rst_req_valid", {31'b0, im_bus.req_valid}, 32'h0);
      chk("rst_busy",      {31'b0, im_busy}, 32'h1);
      chk("rst_ifid_valid",{31'b0, ifid_valid}, 32'h0);
      chk("rst_ifid_pc",   ifid_pc,          32'h0);
      chk("rst_ifid_inst", ifid_inst,        NOP_INST);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance the model, step the clock.
   task automatic run_cycle(input bit r, input bit s, input bit rdy, input bit rv, input logic [31:0] tgt);
      bit          rv_eff, exp_dlv;
      logic [31:0] np, d_pc, d_inst;
      rv_eff  = rv && m_flight;
      np      = r ? tgt : m_pc + 32'd4;
      redirect = r; stall = s; new_pc = np;
      im_bus.req_ready = rdy;
      im_bus.rsp_valid = rv_eff;
      im_bus.rsp_data  = rv_eff ? inst_of(out_addr) : 32'hDEAD_BEEF;
      exp_dlv = !r && !s && ((m_flight && rv_eff && !m_killed) || m_buf);
      d_pc    = m_addr;
      d_inst  = m_buf ? m_buf_data : inst_of(out_addr);
      #2;
      chk("pc",         pc,                           m_pc);
      chk("req_valid",  {31'b0, im_bus.req_valid},    {31'b0, m_present});
      if (m_present) chk("req_addr", im_bus.req_addr, m_addr);
      chk("busy",       {31'b0, im_busy},             {31'b0, !exp_dlv});
      chk("ifid_valid", {31'b0, ifid_valid},          {31'b0, m_ifid_v});
      chk("ifid_pc",    ifid_pc,                      m_ifid_pc);
      chk("ifid_inst",  ifid_inst,                    m_ifid_inst);

      if (m_fresh) begin
         m_fresh = 0; m_present = 1;
         if (r) m_pc = tgt;
         m_addr = m_pc;
      end else if (m_present) begin
         if (r) begin m_pc = tgt; m_killed = 1; end
         if (rdy) begin m_present = 0; m_flight = 1; out_addr = m_addr; end
      end else if (m_flight) begin
         if (rv_eff) begin
            m_flight = 0;
            if (m_killed || r) begin
               m_killed = 0;
               if (r) m_pc = tgt;
               m_addr = m_pc; m_present = 1;
            end else if (s) begin
               m_buf = 1; m_buf_data = inst_of(out_addr);
            end else begin
               m_pc = np; m_addr = np; m_present = 1;
            end
         end else if (r) begin
            m_pc = tgt; m_killed = 1;
         end
      end else if (m_buf) begin
         if (r || !s) begin
            m_buf = 0; m_pc = np; m_addr = np; m_present = 1;
         end
      end

      if (r)            m_ifid_v = 0;
      else if (s)       m_ifid_v = m_ifid_v;
      else if (exp_dlv) begin m_ifid_v = 1; m_ifid_pc = d_pc; m_ifid_inst = d_inst; end
      else              m_ifid_v = 0;

      @(posedge clk); #1;
   endtask

   initial begin
      do_reset();
      // Best-case stream plus a 3-cycle ready stall on the 0x4 request
      run_cycle(0,0,0,0,0);                 // IDLE
      run_cycle(0,0,1,0,0);                 // REQ 0x0 accepted
      run_cycle(0,0,0,1,0);                 // deliver 0x0
      for (int i = 0; i < 3; i++) begin
         chk("stable_addr", im_bus.req_addr, 32'h4);
         run_cycle(0,0,0,0,0);
      end
      run_cycle(0,0,1,0,0);                 // REQ 0x4 accepted
      run_cycle(0,0,0,1,0);                 // deliver 0x4
      run_cycle(0,0,1,0,0);                 // REQ 0x8 accepted
      chk("ifid_pc_4", ifid_pc, 32'h4);
      run_cycle(1,0,0,0,32'h80);            // redirect in WAIT
      run_cycle(1,0,0,0,32'h100);           // later redirect wins
      run_cycle(0,0,0,1,0);                 // stale 0x8 response dropped
      chk("redir_addr_100", im_bus.req_addr, 32'h100);
      run_cycle(0,0,1,0,0);
      run_cycle(0,0,0,1,0);                 // deliver 0x100
      chk("ifid_pc_100", ifid_pc, 32'h100);
      run_cycle(0,0,1,0,0);                 // REQ 0x104 accepted
      run_cycle(1,0,0,1,32'h200);           // redirect with response
      chk("redir_addr_200", im_bus.req_addr, 32'h200);
      run_cycle(0,0,1,0,0);
      run_cycle(0,1,0,1,0);                 // response under stall -> HOLD
      run_cycle(0,1,0,0,0);
      run_cycle(0,0,0,0,0);                 // release: deliver buffer
      chk("hold_ifid_pc",   ifid_pc,   32'h200);
      chk("hold_ifid_inst", ifid_inst, inst_of(32'h200));
      chk("hold_pc",        pc,        32'h204);
      run_cycle(0,0,1,0,0);
      run_cycle(0,1,0,1,0);                 // HOLD again
      run_cycle(1,1,0,0,32'h300);           // redirect beats stall in HOLD
      chk("redir_addr_300", im_bus.req_addr, 32'h300);
      run_cycle(0,0,1,0,0);
      run_cycle(0,0,0,0,0);                 // WAIT, no response
      do_reset();                           // reset mid-WAIT

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            run_cycle($urandom_range(0,7) == 0, $urandom_range(0,3) == 0,
                      1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                      $urandom & 32'h0000_FFFC);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that owns the architectural fetch PC register and issues single-outstanding read requests to the instruction-memory bus master. It delivers fetched instructions into the IF/ID pipeline register and drives `im_busy` back to the next-PC adder. It consumes the adder's `new_pc` and applies redirects from branch, interrupt or MRET without corrupting in-flight bus transactions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `new_pc` in 32: next PC from the PC adder; either pc+4 or a redirect target.
- `redirect` in 1: control-flow change (Flush | interrupt_taken | MRET); `new_pc` is the target.
- `stall` in 1: downstream hold (hazard, DM busy, WFI); IF/ID must not change.
- `pc` out 32: current fetch PC, fed back to the PC adder.
- `im_req_valid` out 1: read request valid.
- `im_req_addr` out 32: read address.
- `im_req_ready` in 1: request accepted by the memory master.
- `im_rsp_valid` in 1: read data valid for one cycle. No backpressure.
- `im_rsp_data` in 32: instruction word.
- `im_busy` out 1: PC is not advancing this cycle.
- `ifid_valid` out 1: IF/ID holds a live instruction.
- `ifid_pc` out 32: address of the IF/ID instruction.
- `ifid_inst` out 32: IF/ID instruction.

## Operation
- Internal state:
  - FSM states: IDLE, REQ, WAIT, HOLD.
  - `req_addr` register.
  - `squash` flag.
  - 32-bit hold buffer.
- Deliver event: a non-squashed response is written to IF/ID. PC loads `new_pc` only on deliver or redirect.
- IDLE: entered only from reset. Next cycle goes to REQ, with `req_addr` <= `pc`.
- REQ:
  - `im_req_valid`=1 and `im_req_addr`=`req_addr`.
  - Valid and address stay stable until `im_req_ready`.
  - On `im_req_ready`, go to WAIT.
- WAIT, on `im_rsp_valid`:
  - If `squash` or `redirect`: discard the data and clear `squash`. Go to REQ with `req_addr` <= updated `pc`.
  - Else if `stall`: store the data in the hold buffer and go to HOLD.
  - Else deliver: `ifid_pc`<=`req_addr`, `ifid_inst`<=data, `ifid_valid`<=1, `pc`<=`new_pc`. Go to REQ with `req_addr`<=`new_pc`.
- HOLD:
  - On `redirect`: drop the buffer, `pc`<=`new_pc`, go to REQ.
  - Else on `~stall`: deliver the buffer (`ifid_pc`=`req_addr`), `pc`<=`new_pc`, go to REQ.
- Redirect in REQ or WAIT with no response that cycle: `pc`<=`new_pc` and `squash`<=1. The outstanding request completes and its response is discarded.
- Repeated redirects while `squash`=1: only the last target is kept in `pc`; `squash` stays 1.
- IF/ID update priority, per cycle:
  1. `redirect`: `ifid_valid`<=0.
  2. `stall`: hold all IF/ID fields.
  3. Deliver: load IF/ID.
  4. Otherwise: `ifid_valid`<=0 (bubble). `ifid_pc`/`ifid_inst` hold their values.
- `im_busy` is combinational: 0 exactly in a deliver cycle, 1 otherwise. The adder therefore presents pc+4 only when the stage advances.
- `im_rsp_valid` outside WAIT is a protocol violation and is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, FSM=IDLE, `squash`=0, `req_addr`=`RESET_PC`, `ifid_valid`=0, `ifid_pc`=0, `ifid_inst`=32'h0000_0013 (NOP), `im_req_valid`=0, `im_busy`=1.
- `rst` has priority over all events. Reset mid-transaction abandons the transaction; the memory master is reset by the same `rst`.
- First request: `im_req_valid` rises in the second cycle after `rst` deasserts.
- Best case (ready in the REQ cycle, response the cycle after):
  - Handshake at cycle t.
  - Deliver at t+1.
  - IF/ID visible and next REQ at t+2.
  - Throughput: one instruction per 2 cycles.
- `redirect` and `stall` are sampled every cycle. A redirect always wins over stall.

## Structure
- Shared `cpu_pkg` holds:
  - `fetch_state_t` enum (IDLE/REQ/WAIT/HOLD).
  - `NOP_INST` = 32'h0000_0013.
  - `RESET_PC_DEFAULT`.
- Single module; no sub-module is warranted. The hold buffer and IF/ID register stay inline.

## Test plan
- Reset, then ready=1 with response 1 cycle after each handshake, `new_pc`=pc+4 → IF/ID shows (0x0, i0), (0x4, i1), (0x8, i2) every 2 cycles; `im_busy` is low only in deliver cycles.
- Hold ready=0 for 3 cycles → `im_req_valid`/addr stay stable at 0x4; `pc` unchanged; `im_busy`=1 throughout.
- Redirect to 0x100 while in WAIT for 0x8 → the 0x8 response is discarded, next request is 0x100, `ifid_valid`=0 until 0x100 is delivered.
- Redirect to 0x200 in the same cycle the response arrives → data dropped, `squash` remains 0, next request is 0x200.
- Response arrives with `stall`=1 for 2 cycles → HOLD; IF/ID unchanged; on release, IF/ID = buffered word with correct `ifid_pc`; `pc` advances once.
- Redirect during HOLD, then `rst` asserted mid-WAIT → buffer dropped, request goes to target; after `rst`, all outputs are at reset values.
